// File: rtl/yarvi_uart_rx_if.sv
// Ready/valid byte stream from the UART receiver to its consumer (htif).
// master = byte producer (receiver), slave = byte consumer.
interface yarvi_uart_rx_if;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/yarvi_uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small
// byte FIFO that presents a ready/valid stream with one-cycle error pulses.
module yarvi_uart_rx #(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int FIFO_LOG2 = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             uart_rxd,
    yarvi_uart_rx_if.master  rx,
    output logic             framing_error,
    output logic             overrun,
    output logic             parity_error
);
    localparam int DIV   = CLOCK_HZ / BAUD;
    localparam int CW    = $clog2(DIV);
    localparam int DEPTH = 1 << FIFO_LOG2;

    localparam logic [CW-1:0]        CNT_RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0]        CNT_HALF   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);
    localparam logic [FIFO_LOG2:0]   COUNT_ONE  = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    logic          rxd_meta_reg;
    logic          rxs_reg;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          framing_error_reg;
    logic          overrun_reg;
    logic          parity_bad;

    logic [7:0]           mem_reg [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_reg;
    logic [FIFO_LOG2-1:0] rd_ptr_reg;
    logic [FIFO_LOG2:0]   count_reg;

    logic tick;
    logic push;
    logic pop;
    logic fifo_full;
    logic accept;

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg;
    logic parity_error_reg;
    assign parity_bad   = parity_bad_reg;
    assign parity_error = parity_error_reg;
`else
    assign parity_bad   = 1'b0;
    assign parity_error = 1'b0;
`endif

    assign tick      = (cnt_reg == '0);
    // A byte is offered only when the stop bit is high and parity (if any) matched.
    assign push      = (state_reg == STOP) && tick && rxs_reg && !parity_bad;
    assign fifo_full = (count_reg == FULL_COUNT);
    assign pop       = rx.rx_valid && rx.rx_ready;
    assign accept    = push && (!fifo_full || pop);

    assign rx.rx_valid    = (count_reg != '0);
    assign rx.rx_data     = mem_reg[rd_ptr_reg];
    assign framing_error  = framing_error_reg;
    assign overrun        = overrun_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_reg      <= 1'b1;
            rxs_reg           <= 1'b1;
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            bit_idx_reg       <= '0;
            shift_reg         <= '0;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg    <= 1'b0;
            parity_error_reg  <= 1'b0;
`endif
        end else begin
            rxd_meta_reg      <= uart_rxd;
            rxs_reg           <= rxd_meta_reg;
            framing_error_reg <= 1'b0;
            overrun_reg       <= push && fifo_full && !pop;
            cnt_reg           <= tick ? CNT_RELOAD : cnt_reg - CNT_ONE;
`ifdef UART_RX_PARITY_EN
            parity_error_reg  <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    // Half-bit delay so every later sample lands mid-bit.
                    if (!rxs_reg) begin
                        state_reg <= START;
                        cnt_reg   <= CNT_HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxs_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg   <= DATA;
                            bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                            parity_bad_reg <= 1'b0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= {rxs_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        parity_bad_reg <= (^shift_reg) ^ rxs_reg;
                        state_reg      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (rxs_reg) begin
                            state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_error_reg <= parity_bad_reg;
`endif
                        end else begin
                            framing_error_reg <= 1'b1;
                            state_reg         <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs_reg) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept) begin
                mem_reg[wr_ptr_reg] <= shift_reg;
                wr_ptr_reg          <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_yarvi_uart_rx.sv
// Directed and randomised frames against a queue-based model of the receiver:
// good frames become bytes, bad stop bits become framing pulses, excess bytes overrun.
module tb_yarvi_uart_rx;
    localparam int CLOCK_HZ  = 1600;
    localparam int BAUD      = 100;
    localparam int FIFO_LOG2 = 2;
    localparam int DIV       = CLOCK_HZ / BAUD;
    localparam int DEPTH     = 1 << FIFO_LOG2;

    logic clock = 1'b0;
    logic reset_n;
    logic uart_rxd;
    logic framing_error;
    logic overrun;
    logic parity_error;

    yarvi_uart_rx_if rx_if ();

    yarvi_uart_rx #(
        .CLOCK_HZ (CLOCK_HZ),
        .BAUD     (BAUD),
        .FIFO_LOG2(FIFO_LOG2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .uart_rxd     (uart_rxd),
        .rx           (rx_if),
        .framing_error(framing_error),
        .overrun      (overrun),
        .parity_error (parity_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vcnt = 0;
    int rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Observer: records delivered bytes and error pulses; never compares.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
            if (rx_if.rx_valid) vcnt <= vcnt + 1;
            if (framing_error) fe_cnt <= fe_cnt + 1;
            if (overrun) ov_cnt <= ov_cnt + 1;
            if (parity_error) pe_cnt <= pe_cnt + 1;
            if (rx_if.rx_valid && !prev_valid) rise_cyc <= cyc;
            prev_valid <= rx_if.rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one frame bit-by-bit for up to max_cycles clocks; line left at the last level.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                               input int max_cycles, output int start_at);
        logic [10:0] bits;
        int nbits;
`ifdef UART_RX_PARITY_EN
        bits  = {stop_bit, par_bit, b, 1'b0};
        nbits = 11;
`else
        bits  = {1'b1, stop_bit, b, 1'b0};
        nbits = 10;
        if (par_bit) nbits = 10;
`endif
        start_at = cyc;
        for (int c = 0; c < nbits * DIV && c < max_cycles; c++) begin
            uart_rxd = bits[c / DIV];
            step(1);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        int s;
        drive_frame(b, stop_bit, ^b, 1 << 20, s);
    endtask

    initial begin
        int base_got, base_fe, base_ov, base_pe, base_v, st, nbad;
        logic [7:0] exp_q [$];
        logic [7:0] pat [5];
        logic [7:0] b;
        logic bad;

        reset_n = 1'b0;
        uart_rxd = 1'b1;
        rx_if.rx_ready = 1'b0;
        step(3);
        check("reset_valid", rx_if.rx_valid, 0);
        check("reset_data", rx_if.rx_data, 8'h00);
        check("reset_pulses", {framing_error, overrun, parity_error}, 0);
        reset_n = 1'b1;
        step(4);
        check("idle_valid", rx_if.rx_valid, 0);

        // Single byte, consumer always ready.
        rx_if.rx_ready = 1'b1;
        base_got = got_q.size(); base_fe = fe_cnt; base_ov = ov_cnt; base_pe = pe_cnt; base_v = vcnt;
        drive_frame(8'hA5, 1'b1, ^8'hA5, 1 << 20, st);
        step(2 * DIV);
        check("a5_count", got_q.size() - base_got, 1);
        if (got_q.size() > base_got) check("a5_data", got_q[base_got], 8'hA5);
        check("a5_valid_cycles", vcnt - base_v, 1);
        check("a5_latency_window", ((rise_cyc - st) >= 9 * DIV + DIV / 2) && ((rise_cyc - st) <= 9 * DIV + DIV / 2 + 6), 1);
        check("a5_no_errors", (fe_cnt - base_fe) + (ov_cnt - base_ov) + (pe_cnt - base_pe), 0);

        // Overflow: depth+1 bytes while the consumer stalls.
        rx_if.rx_ready = 1'b0;
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'h3C; pat[4] = 8'h81;
        base_got = got_q.size(); base_ov = ov_cnt; base_fe = fe_cnt;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            send(pat[i], 1'b1);
            if (i < DEPTH) exp_q.push_back(pat[i]);
        end
        step(DIV);
        check("ovf_overrun", ov_cnt - base_ov, 5 - DEPTH);
        check("ovf_framing", fe_cnt - base_fe, 0);
        check("ovf_valid", rx_if.rx_valid, 1);
        check("ovf_head", rx_if.rx_data, exp_q[0]);
        step(5);
        check("ovf_head_stable", rx_if.rx_data, exp_q[0]);
        rx_if.rx_ready = 1'b1;
        step(DEPTH + 4);
        check("ovf_pop_count", got_q.size() - base_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base_got + i < got_q.size()) check($sformatf("ovf_pop%0d", i), got_q[base_got + i], exp_q[i]);
        check("ovf_empty", rx_if.rx_valid, 0);

        // Short low glitch on an idle line.
        base_got = got_q.size(); base_fe = fe_cnt; base_ov = ov_cnt; base_pe = pe_cnt;
        uart_rxd = 1'b0;
        step(4);
        uart_rxd = 1'b1;
        step(2 * DIV);
        check("glitch_no_byte", got_q.size() - base_got, 0);
        check("glitch_no_pulse", (fe_cnt - base_fe) + (ov_cnt - base_ov) + (pe_cnt - base_pe), 0);

        // Low stop bit followed by a held-low line, then a good frame.
        send(8'h12, 1'b0);
        uart_rxd = 1'b0;
        step(40);
        uart_rxd = 1'b1;
        step(2 * DIV);
        check("frm_pulse", fe_cnt - base_fe, 1);
        check("frm_no_byte", got_q.size() - base_got, 0);
        send(8'h34, 1'b1);
        step(2 * DIV);
        check("frm_next_count", got_q.size() - base_got, 1);
        if (got_q.size() > base_got) check("frm_next_data", got_q[base_got], 8'h34);
        check("frm_single_pulse", fe_cnt - base_fe, 1);

        // Reset mid bit 4 with two bytes queued.
        rx_if.rx_ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        step(DIV);
        check("rst_queued", rx_if.rx_valid, 1);
        drive_frame(8'h99, 1'b1, ^8'h99, 5 * DIV + DIV / 2, st);
        #2;
        reset_n = 1'b0;
        uart_rxd = 1'b1;
        #1;
        check("rst_valid_now", rx_if.rx_valid, 0);
        check("rst_data_now", rx_if.rx_data, 8'h00);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(2 * DIV);
        check("rst_fifo_empty", rx_if.rx_valid, 0);
        base_got = got_q.size();
        rx_if.rx_ready = 1'b1;
        send(8'h7E, 1'b1);
        step(2 * DIV);
        check("rst_next_count", got_q.size() - base_got, 1);
        if (got_q.size() > base_got) check("rst_next_data", got_q[base_got], 8'h7E);

`ifdef UART_RX_PARITY_EN
        base_got = got_q.size(); base_pe = pe_cnt;
        begin
            int s;
            drive_frame(8'h07, 1'b1, 1'b1, 1 << 20, s);
            step(2 * DIV);
            check("par_good_count", got_q.size() - base_got, 1);
            drive_frame(8'h07, 1'b1, 1'b0, 1 << 20, s);
            step(2 * DIV);
            check("par_bad_pulse", pe_cnt - base_pe, 1);
            check("par_bad_no_byte", got_q.size() - base_got, 1);
        end
`endif

        // Random frames, some with a low stop bit, random idle gaps.
        exp_q.delete();
        nbad = 0;
        base_got = got_q.size(); base_fe = fe_cnt; base_ov = ov_cnt; base_pe = pe_cnt;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send(b, !bad);
            if (bad) begin
                nbad++;
                uart_rxd = 1'b1;
                step(DIV);
            end else begin
                exp_q.push_back(b);
            end
            step($urandom_range(0, 20));
        end
        step(2 * DIV);
        check("rnd_count", got_q.size() - base_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base_got + i < got_q.size()) check($sformatf("rnd_byte%0d", i), got_q[base_got + i], exp_q[i]);
        check("rnd_framing", fe_cnt - base_fe, nbad);
        check("rnd_overrun", ov_cnt - base_ov, 0);
        check("rnd_parity", pe_cnt - base_pe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
